// File: rtl/seq_playback_ctrl.sv
// seq_playback_ctrl
//   Plays a programmable byte pattern over a valid/ready stream. The pattern
//   table is rewritable from the config port while idle and resets to the
//   standard pattern AF BC E2 78 FF E2 0B 8D. A start plays entries
//   0..cfg_len for cfg_repeat passes (0 = forever), honouring back-pressure.
//
// Ports
//   clk, reset                    : single clock, async active-high reset
//   cfg_we/cfg_addr/cfg_wdata     : table write port (honoured only in IDLE)
//   cfg_len, cfg_repeat           : last index of a pass, pass count (0 = forever)
//   start, stop                   : level controls, sampled every cycle
//   out_valid/out_ready/out_data  : output stream
//   busy                          : high while playing
//   done                          : one-cycle pulse on natural completion
//   pass_cnt                      : passes completed since the last start
module seq_playback_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int REP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic              start,
  input  logic              stop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [REP_W-1:0]  pass_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic [DATA_W-1:0] default_entry(input int i);
    logic [7:0] b;
    case (i % 8)
      0:       b = 8'hAF;
      1:       b = 8'hBC;
      2:       b = 8'hE2;
      3:       b = 8'h78;
      4:       b = 8'hFF;
      5:       b = 8'hE2;
      6:       b = 8'h0B;
      default: b = 8'h8D;
    endcase
    return DATA_W'(b);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]    rep_q, rep_d;
  logic [REP_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [ADDR_W-1:0]   idx_inc;

  // The table is small and its reset contents are functional (the default
  // pattern), so it lives in flops rather than a RAM macro.
  // NOTE: the table is reset explicitly; a RAM without reset would come up
  // with arbitrary contents instead of the default pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      rep_q      <= '0;
      pass_cnt_q <= '0;
      out_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= default_entry(i);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      rep_q      <= rep_d;
      pass_cnt_q <= pass_cnt_d;
      out_data_q <= out_data_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    rep_d      = rep_q;
    pass_cnt_d = pass_cnt_q;
    out_data_d = out_data_q;
    mem_d      = mem_q;
    idx_inc    = idx_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        // Writes land before a same-cycle start reads entry 0, so the first
        // output already reflects the new value.
        if (cfg_we) mem_d[cfg_addr] = cfg_wdata;
        if (start && !stop) begin
          len_d      = cfg_len;
          rep_d      = cfg_repeat;
          idx_d      = '0;
          pass_cnt_d = '0;
          out_data_d = mem_d[0];
          state_d    = RUN;
        end
      end

      RUN: begin
        // out_valid is high throughout RUN, so out_ready alone marks a transfer.
        if (out_ready) begin
          if (idx_q != len_q) begin
            idx_d      = idx_inc;
            out_data_d = mem_q[idx_inc];
          end else begin
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + REP_W'(1);
            if (rep_q == REP_W'(1)) begin
              state_d = DONE;
            end else begin
              idx_d      = '0;
              out_data_d = mem_q[0];
              if (rep_q != '0) rep_d = rep_q - REP_W'(1);
            end
          end
        end
        // Stop wins over natural completion (no done pulse) and leaves the
        // last presented value on out_data; index and pass count still
        // reflect a same-cycle transfer.
        if (stop) begin
          state_d    = IDLE;
          out_data_d = out_data_q;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign out_data  = out_data_q;
  assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_seq_playback_ctrl.sv
// Testbench for seq_playback_ctrl. Stimulus pushes the expected transfer
// stream (derived from a plain array copy of the table) into a queue; a
// negedge monitor pops and compares on every accepted transfer, checks data
// stability under back-pressure and pass_cnt against the transfer count.
module tb_seq_playback_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [2:0] cfg_len;
  logic [7:0] cfg_repeat;
  logic       start;
  logic       stop;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
  logic [7:0] pass_cnt;

  seq_playback_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_len    (cfg_len),
    .cfg_repeat (cfg_repeat),
    .start      (start),
    .stop       (stop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .pass_cnt   (pass_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_xfer_cyc = 0;
  int start_cyc = 0;
  int run_xfers = 0;
  int plen      = 1;

  logic [7:0] tbl [8];
  logic [7:0] exp_q [$];
  bit         hold_chk = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_pass(input int xfers, input int per_pass);
    int v;
    v = xfers / per_pass;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic load_default_table();
    tbl[0] = 8'hAF; tbl[1] = 8'hBC; tbl[2] = 8'hE2; tbl[3] = 8'h78;
    tbl[4] = 8'hFF; tbl[5] = 8'hE2; tbl[6] = 8'h0B; tbl[7] = 8'h8D;
  endtask

  // Monitor: compares every accepted transfer against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(hold_data));
      end
      if (out_valid)
        check("pass_cnt_run", 32'(pass_cnt), 32'(sat_pass(run_xfers, plen)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_xfer: got 0x%0h, want no transfer (t=%0t)", out_data, $time);
        end else begin
          check("xfer_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        run_xfers++;
        last_xfer_cyc = cyc;
      end
      hold_chk  = out_valid && !out_ready && !stop;
      hold_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    tbl[a] = d;
  endtask

  task automatic push_stream(input int len, input int k);
    for (int i = 0; i < k; i++) exp_q.push_back(tbl[i % (len + 1)]);
  endtask

  // Issues a start; for finite repeat counts the whole expected stream is queued.
  task automatic start_run(input int len, input int rep);
    cfg_len = 3'(len); cfg_repeat = 8'(rep); start = 1'b1;
    for (int p = 0; p < rep; p++) push_stream(len, len + 1);
    run_xfers = 0;
    plen = len + 1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    start_cyc = cyc;
    check("start_latency_valid", 32'(out_valid), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
  endtask

  // mode 0: ready always 1, 1: toggle 1,0,1,0..., 2: random
  task automatic drive_until_done(input int mode, input int exp_pass);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 2 == 0);
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("done_after_last_xfer", 32'(cyc - last_xfer_cyc), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_valid", 32'(out_valid), 32'd0);
    check("done_pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    check("done_queue_empty", 32'(exp_q.size()), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_pass_hold", 32'(pass_cnt), 32'(exp_pass));
  endtask

  // Random back-pressure until k transfers; then stop (mode 0) on the k-th
  // transfer or reset (mode 1) right after it.
  task automatic run_k(input int k, input int mode);
    int cnt, n;
    bit r;
    cnt = 0; n = 0;
    while (n < 5000) begin
      r = ($urandom_range(0, 9) < 7);
      out_ready = r;
      if (out_valid && r) begin
        cnt++;
        if (mode == 0 && cnt == k) stop = 1'b1;
      end
      tick();
      n++;
      cfg_we = 1'b0;
      if (cnt == k) break;
    end
    stop = 1'b0; out_ready = 1'b0;
    check("run_k_count", 32'(cnt), 32'(k));
    check("run_k_queue_empty", 32'(exp_q.size()), 32'd0);
    if (mode == 0) begin
      check("stop_valid", 32'(out_valid), 32'd0);
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_no_done", 32'(done), 32'd0);
      tick();
      check("stop_no_done_later", 32'(done), 32'd0);
      check("stop_idle_valid", 32'(out_valid), 32'd0);
    end else begin
      reset = 1'b1;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
      tick();
      reset = 1'b0;
      exp_q.delete();
      load_default_table();
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw, len, rep;
    logic [2:0] a;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_len = '0; cfg_repeat = '0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    load_default_table();
    tick(); tick();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pass_cnt", 32'(pass_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Full default pattern, one pass, no back-pressure.
    start_run(7, 1);
    drive_until_done(0, 1);
    check("t1_run_length", 32'(last_xfer_cyc - start_cyc), 32'd7);

    // Two short passes under alternating ready.
    start_run(2, 2);
    drive_until_done(1, 2);

    // start with stop in IDLE does nothing.
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("start_stop_valid", 32'(out_valid), 32'd0);
      check("start_stop_busy", 32'(busy), 32'd0);
    end
    start = 1'b0; stop = 1'b0;
    tick();

    // start held through DONE: restart only after an IDLE cycle.
    cfg_len = 3'd0; cfg_repeat = 8'd1; start = 1'b1; out_ready = 1'b1;
    exp_q.push_back(tbl[0]); run_xfers = 0; plen = 1;
    tick();
    check("held_run1_busy", 32'(busy), 32'd1);
    tick();
    check("held_done", 32'(done), 32'd1);
    check("held_done_busy", 32'(busy), 32'd0);
    exp_q.push_back(tbl[0]);
    tick();
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_idle_valid", 32'(out_valid), 32'd0);
    run_xfers = 0;
    tick();
    check("held_run2_busy", 32'(busy), 32'd1);
    check("held_run2_valid", 32'(out_valid), 32'd1);
    start = 1'b0;
    tick();
    check("held_done2", 32'(done), 32'd1);
    out_ready = 1'b0;
    tick();

    // Rewritten table, infinite play, write during RUN ignored.
    cfg_write(3'd0, 8'h11);
    cfg_write(3'd1, 8'h22);
    start_run(1, 0);
    push_stream(1, 10);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 8'h99;
    run_k(10, 0);
    check("t3_pass_cnt", 32'(pass_cnt), 32'd5);

    // Reset mid-pass after another rewrite: table reverts to default.
    cfg_write(3'd2, 8'h33);
    start_run(7, 0);
    push_stream(7, 3);
    run_k(3, 1);
    start_run(7, 1);
    drive_until_done(2, 1);

    // Stop together with the transfer of index 2, then restart at AF.
    start_run(7, 0);
    push_stream(7, 3);
    run_k(3, 0);
    check("t4_pass_cnt", 32'(pass_cnt), 32'd0);
    start_run(7, 1);
    drive_until_done(2, 1);

    // pass_cnt saturates with single-entry passes.
    start_run(0, 0);
    push_stream(0, 260);
    run_k(260, 0);
    check("sat_pass_cnt", 32'(pass_cnt), 32'd255);

    // Randomized runs, sometimes with a write in the same cycle as start.
    for (int it = 0; it < 8; it++) begin
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++)
        cfg_write(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      len = int'($urandom_range(0, 7));
      rep = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        a = 3'($urandom_range(0, 7));
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = 8'($urandom_range(0, 255));
        tbl[a] = cfg_wdata;
      end
      start_run(len, rep);
      drive_until_done(2, rep);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_playback_ctrl.md
Name: seq_playback_ctrl

Overview:
Controller that sequences a programmable byte-pattern generator and delivers the pattern over a valid/ready stream. It holds a DEPTH-entry pattern table, which resets to the standard pattern AF BC E2 78 FF E2 0B 8D. The table is rewritable through a config port while the block is idle. On start it plays entries 0..cfg_len for a programmed number of passes, or forever, honouring downstream back-pressure. The block sits between the system control/config bus and any sink that consumes the sequence.

Parameters:
DATA_W, 8, width of each pattern entry and of out_data
ADDR_W, 3, pattern index width; DEPTH = 2**ADDR_W entries (8)
REP_W, 8, width of the repeat count and of pass_cnt

Ports:
clk  in  1  single clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  pattern table write strobe
cfg_addr  in  ADDR_W  pattern table write index
cfg_wdata  in  DATA_W  pattern table write data
cfg_len  in  ADDR_W  last index to play; a pass is entries 0..cfg_len
cfg_repeat  in  REP_W  number of passes; 0 = play forever
start  in  1  begin playback (level, sampled each cycle)
stop  in  1  abort playback (level, sampled each cycle)
out_valid  out  1  out_data holds a valid pattern entry
out_ready  in  1  sink accepts out_data this cycle
out_data  out  DATA_W  current pattern entry
busy  out  1  1 while in RUN
done  out  1  one-cycle pulse on natural completion
pass_cnt  out  REP_W  passes fully completed since the last start

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- Reset values:
  - state = IDLE; out_valid = 0, out_data = 0, busy = 0, done = 0, pass_cnt = 0.
  - Internal index, length and repeat registers = 0.
  - Pattern table = AF BC E2 78 FF E2 0B 8D (index 0..7).
- Reset asserted mid-playback aborts immediately. Any cfg writes made before the reset are lost.
- Handshake: a transfer occurs on a cycle where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data is held stable.
  - out_valid never drops without a transfer, except on stop or reset.
- Config writes:
  - cfg_we is honoured only in IDLE; the table updates on that edge.
  - cfg_we is ignored in RUN and DONE.
  - A write and a start in the same cycle: the write lands first, and the playback reads the new value.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0: latch len_q = cfg_len and rep_q = cfg_repeat; set idx = 0 and pass_cnt = 0.
  - On that same edge: out_data = table[0], out_valid = 1, busy = 1, go to RUN. Latency is 1 cycle from start sampled to first valid.
  - start and stop both 1: stay in IDLE.
- RUN:
  - Transfer with idx != len_q: idx = idx+1 and out_data = table[idx+1] on the same edge. This gives back-to-back output with no bubbles.
  - Transfer with idx == len_q (end of pass): pass_cnt increments, saturating at all-ones.
    - If rep_q == 1: out_valid = 0, busy = 0, go to DONE.
    - Otherwise: idx = 0 and out_data = table[0]. rep_q decrements only when it is non-zero (0 = infinite).
  - start is ignored.
  - stop=1: go to IDLE next edge with out_valid = 0 and busy = 0, and no done pulse. A transfer in the same cycle still completes and is counted (idx and pass_cnt update). out_data retains its last value.
  - cfg_len = 0 is legal: each pass is the single entry table[0].
- DONE:
  - done = 1 for exactly this one cycle, then go to IDLE unconditionally.
  - start during DONE is ignored; it must be re-asserted in IDLE.
- pass_cnt holds its value in IDLE until the next accepted start.
- The index wraps only via the end-of-pass rule; idx never exceeds len_q.

Test Plan:
1. Reset, cfg_len=7, cfg_repeat=1, out_ready=1, pulse start:
   - out_data AF BC E2 78 FF E2 0B 8D on 8 consecutive cycles, starting 1 cycle after start.
   - done pulses the cycle after 8D transfers; pass_cnt=1; busy=0.
2. cfg_len=2, cfg_repeat=2, toggle out_ready 1,0,1,0:
   - Transferred stream is AF BC E2 AF BC E2.
   - out_data is stable on every ready=0 cycle; done occurs once and pass_cnt=2.
3. In IDLE, write addr0=0x11 and addr1=0x22; then cfg_len=1, cfg_repeat=0, start:
   - Output is 11 22 11 22 … indefinitely; pass_cnt increments every 2 transfers.
   - A cfg_we to addr0=0x99 during RUN does not change the output.
4. cfg_repeat=0, cfg_len=7; assert stop together with the transfer of E2 (index 2):
   - out_valid=0 the next cycle and the state returns to IDLE with no done.
   - A new start begins again at AF.
5. Assert reset for 1 cycle mid-pass after a table rewrite:
   - All outputs are 0 immediately.
   - The table reverts, so a subsequent len=7 run emits the default AF…8D pattern.
6. start and stop both high in IDLE -> out_valid stays 0 and busy stays 0. start held high through DONE -> no restart until the IDLE cycle after DONE.
